// File: rtl/reg_if_pkg.sv
// Shared types and constants for the switch register-access bus initiator.
package reg_if_pkg;

    localparam int BUS_AW = 8;
    localparam int BUS_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RSP_OK       = 2'b00,
        RSP_TIMEOUT  = 2'b01,
        RSP_BAD_ADDR = 2'b10
    } rsp_err_e;

endpackage

// File: rtl/reg_timeout_cnt.sv
// Saturating ack-wait counter; expired_o is high once the count sits at TIMEOUT_CYCLES-1.
module reg_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int            CW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/reg_cfg_initiator.sv
// Register-bus initiator: one host command -> one guarded bus access -> one response.
module reg_cfg_initiator
    import reg_if_pkg::*;
#(
    parameter int NUM_OF_REG     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [BUS_AW-1:0] cmd_addr,
    input  logic [BUS_DW-1:0] cmd_wdata,
    output logic              sel_en,
    output logic              wr_rd_s,
    output logic [BUS_AW-1:0] addr,
    output logic [BUS_DW-1:0] wr_data,
    input  logic              ack,
    input  logic [BUS_DW-1:0] rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [BUS_DW-1:0] rsp_rdata,
    output logic [1:0]        rsp_err
);

    state_e            state_q, state_d;
    logic              sel_en_q, sel_en_d;
    logic              wr_rd_s_q, wr_rd_s_d;
    logic [BUS_AW-1:0] addr_q, addr_d;
    logic [BUS_DW-1:0] wr_data_q, wr_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [BUS_DW-1:0] rsp_rdata_q, rsp_rdata_d;
    rsp_err_e          rsp_err_q, rsp_err_d;
    logic              cnt_clr, cnt_en, expired;

    reg_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .expired_o(expired)
    );

    // A lingering ack from the previous access must clear before the next one can start.
    assign cmd_ready = (state_q == ST_IDLE) && !ack;

    always_comb begin
        state_d     = state_q;
        sel_en_d    = sel_en_q;
        wr_rd_s_d   = wr_rd_s_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_addr < BUS_AW'(NUM_OF_REG)) begin
                        state_d   = ST_ACCESS;
                        sel_en_d  = 1'b1;
                        wr_rd_s_d = cmd_wr;
                        addr_d    = cmd_addr;
                        wr_data_d = cmd_wdata;
                        cnt_clr   = 1'b1;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = RSP_BAD_ADDR;
                        rsp_rdata_d = '0;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_en = !ack;
                // ack takes priority over an expiry landing in the same cycle.
                if (ack) begin
                    state_d     = ST_RESP;
                    sel_en_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = RSP_OK;
                    rsp_rdata_d = wr_rd_s_q ? '0 : rd_data;
                end else if (expired) begin
                    state_d     = ST_RESP;
                    sel_en_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = RSP_TIMEOUT;
                    rsp_rdata_d = '0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_en_q    <= 1'b0;
            wr_rd_s_q   <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= RSP_OK;
        end else begin
            state_q     <= state_d;
            sel_en_q    <= sel_en_d;
            wr_rd_s_q   <= wr_rd_s_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign sel_en    = sel_en_q;
    assign wr_rd_s   = wr_rd_s_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_reg_cfg_initiator.sv
// Directed bench for reg_cfg_initiator with a small register responder model.
module tb_reg_cfg_initiator;

    localparam int NREG = 4;
    localparam int TO   = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       sel_en, wr_rd_s;
    logic [7:0] addr, wr_data;
    logic       ack;
    logic [7:0] rd_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_cfg_initiator #(
        .NUM_OF_REG    (NREG),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr   (cmd_wr),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .sel_en   (sel_en),
        .wr_rd_s  (wr_rd_s),
        .addr     (addr),
        .wr_data  (wr_data),
        .ack      (ack),
        .rd_data  (rd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    // Responder: ack follows sel_en by one cycle, so it also lingers one cycle after deassert.
    logic       ack_q, ack_en, ack_force, init_regs;
    logic [7:0] regs [NREG];
    logic [7:0] wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_q <= 1'b0;
        else        ack_q <= ack_en && sel_en;
    end
    assign ack     = ack_q | ack_force;
    assign rd_data = ack ? regs[addr[1:0]] : 8'h00;
    assign wr_en   = (sel_en && wr_rd_s && ack) ? (8'h01 << addr[2:0]) : 8'h00;

    always @(posedge clk) begin
        if (init_regs) begin
            regs[0] <= 8'h11;
            regs[1] <= 8'h3C;
            regs[2] <= 8'h00;
            regs[3] <= 8'h00;
        end else if (sel_en && wr_rd_s && ack) begin
            regs[addr[1:0]] <= wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int rv_cyc;
        int stray;
        rst_n     = 1'b0;
        init_regs = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b1;
        ack_en    = 1'b1;
        ack_force = 1'b0;
        #1;
        check("rst_sel_en",    32'(sel_en), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_addr",      32'(addr), 0);
        check("rst_wr_data",   32'(wr_data), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check("rst_rsp_err",   32'(rsp_err), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        repeat (2) @(posedge clk);
        #2;
        init_regs = 1'b0;
        rst_n     = 1'b1;
        tick();

        // Write 0xA5 to register 2
        check("wr_ready_c0", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'd2; cmd_wdata = 8'hA5;
        tick();
        cmd_valid = 1'b0;
        check("wr_sel_c1",     32'(sel_en), 1);
        check("wr_dir_c1",     32'(wr_rd_s), 1);
        check("wr_addr_c1",    32'(addr), 2);
        check("wr_data_c1",    32'(wr_data), 32'hA5);
        check("wr_rspv_c1",    32'(rsp_valid), 0);
        tick();
        check("wr_sel_c2",     32'(sel_en), 1);
        check("wr_wren_c2",    32'(wr_en), 32'h04);
        tick();
        check("wr_sel_c3",     32'(sel_en), 0);
        check("wr_rspv_c3",    32'(rsp_valid), 1);
        check("wr_err_c3",     32'(rsp_err), 0);
        check("wr_rdata_c3",   32'(rsp_rdata), 0);
        check("wr_ready_c3",   32'(cmd_ready), 0);
        tick();
        check("wr_rspv_c4",    32'(rsp_valid), 0);
        check("wr_ready_c4",   32'(cmd_ready), 1);
        check("wr_reg2",       32'(regs[2]), 32'hA5);

        // Read register 1 (0x3C)
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'd1;
        tick();
        cmd_valid = 1'b0;
        check("rd_sel_c1",     32'(sel_en), 1);
        check("rd_dir_c1",     32'(wr_rd_s), 0);
        tick();
        tick();
        check("rd_rspv_c3",    32'(rsp_valid), 1);
        check("rd_rdata_c3",   32'(rsp_rdata), 32'h3C);
        check("rd_err_c3",     32'(rsp_err), 0);
        tick();

        // Out-of-range address
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'd5;
        tick();
        cmd_valid = 1'b0;
        check("bad_sel_c1",    32'(sel_en), 0);
        check("bad_rspv_c1",   32'(rsp_valid), 1);
        check("bad_err_c1",    32'(rsp_err), 2);
        check("bad_rdata_c1",  32'(rsp_rdata), 0);
        tick();
        check("bad_sel_c2",    32'(sel_en), 0);
        check("bad_rspv_c2",   32'(rsp_valid), 0);
        check("bad_ready_c2",  32'(cmd_ready), 1);

        // Responder silent: timeout
        ack_en    = 1'b0;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'd1;
        hi = 0; rv_cyc = 0;
        for (int c = 1; c <= 40 && rv_cyc == 0; c++) begin
            tick();
            if (c == 1) cmd_valid = 1'b0;
            if (sel_en) hi++;
            if (rsp_valid) rv_cyc = c;
        end
        check("to_sel_cycles", 32'(hi), TO);
        check("to_rsp_cycle",  32'(rv_cyc), TO + 1);
        check("to_err",        32'(rsp_err), 1);
        check("to_rdata",      32'(rsp_rdata), 0);
        tick();

        // ack arriving exactly at the timeout limit wins
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'd0;
        for (int c = 1; c <= TO; c++) begin
            tick();
            if (c == 1) cmd_valid = 1'b0;
            if (c == TO) ack_force = 1'b1;
        end
        check("lim_sel_c16",   32'(sel_en), 1);
        tick();
        ack_force = 1'b0;
        check("lim_rspv",      32'(rsp_valid), 1);
        check("lim_err",       32'(rsp_err), 0);
        check("lim_rdata",     32'(rsp_rdata), 32'h11);
        tick();
        ack_en = 1'b1;

        // Back-to-back commands with rsp_ready held low for 3 cycles
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'd3; cmd_wdata = 8'h5A;
        tick();
        cmd_wr = 1'b0;
        check("bb_sel_c1",     32'(sel_en), 1);
        check("bb_ready_c1",   32'(cmd_ready), 0);
        tick();
        for (int c = 3; c <= 5; c++) begin
            tick();
            check("bb_hold_rspv",  32'(rsp_valid), 1);
            check("bb_hold_err",   32'(rsp_err), 0);
            check("bb_hold_rdata", 32'(rsp_rdata), 0);
            check("bb_hold_ready", 32'(cmd_ready), 0);
            check("bb_hold_sel",   32'(sel_en), 0);
        end
        tick();
        rsp_ready = 1'b1;
        check("bb_rspv_c6",    32'(rsp_valid), 1);
        check("bb_ready_c6",   32'(cmd_ready), 0);
        tick();
        check("bb_rspv_c7",    32'(rsp_valid), 0);
        check("bb_ready_c7",   32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        check("bb_sel_c8",     32'(sel_en), 1);
        check("bb_dir_c8",     32'(wr_rd_s), 0);
        check("bb_addr_c8",    32'(addr), 3);
        tick();
        tick();
        check("bb_rspv_c10",   32'(rsp_valid), 1);
        check("bb_rdata_c10",  32'(rsp_rdata), 32'h5A);
        tick();

        // Reset in the middle of an access
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'd1;
        tick();
        cmd_valid = 1'b0;
        check("rst_mid_sel",   32'(sel_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_sel_drop",  32'(sel_en), 0);
        check("rst_mid_rspv_drop", 32'(rsp_valid), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        check("rst_mid_ready", 32'(cmd_ready), 1);
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rsp_valid || sel_en) stray++;
        end
        check("rst_mid_no_rsp", 32'(stray), 0);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("rst_rd_rspv",   32'(rsp_valid), 1);
        check("rst_rd_rdata",  32'(rsp_rdata), 32'h3C);
        check("rst_rd_err",    32'(rsp_err), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_cfg_initiator.md
# reg_cfg_initiator

Initiator for the switch's register-access bus, driving `sel_en`, `wr_rd_s`, `addr` and `wr_data` toward the register responder and waiting for its `ack`/`rd_data`. It accepts single register commands from the host/config side over a valid/ready port. Each command runs one bus access, guarded by an ack timeout, and is answered on a valid/ready response port with read data and status. It sits between the host configuration logic and the switch's register block.

## Interface
- `NUM_OF_REG`, 4: number of implemented registers; legal addresses are 0..NUM_OF_REG-1 (max 8).
- `TIMEOUT_CYCLES`, 16: cycles `ack` may stay low during an access before abort (>= 2).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_wr` in 1: 1 = write, 0 = read.
- `cmd_addr` in 8: register address.
- `cmd_wdata` in 8: write data (ignored for reads).
- `sel_en` out 1: bus select, registered.
- `wr_rd_s` out 1: bus direction, 1 = write, registered.
- `addr` out 8: bus address, registered.
- `wr_data` out 8: bus write data, registered.
- `ack` in 1: responder acknowledge.
- `rd_data` in 8: responder read data, valid while `ack`=1.
- `rsp_valid` out 1: response present, registered.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata` out 8: read data (0 for writes/errors).
- `rsp_err` out 2: 00 OK, 01 TIMEOUT, 10 BAD_ADDR.

## Operation
- FSM states:
  - IDLE: `cmd_ready` = (state==IDLE) && !ack. Combinational; equals !ack after reset.
  - ACCESS: bus access in progress.
  - RESP: response held on the response port.
- IDLE, accept with `cmd_addr` < NUM_OF_REG -> ACCESS.
  - Load `addr`, `wr_rd_s` and `wr_data`; set `sel_en`=1.
  - Clear the timeout counter.
- IDLE, accept with `cmd_addr` >= NUM_OF_REG -> RESP.
  - `rsp_err`=10, `rsp_rdata`=0; `sel_en` never asserted.
- ACCESS: `sel_en`, `wr_rd_s`, `addr` and `wr_data` are held stable.
  - On `ack`=1: capture `rd_data` into `rsp_rdata` for reads (0 for writes), `rsp_err`=00.
  - Then `sel_en`->0 and go to RESP.
  - Each cycle with `ack`=0, the counter increments.
  - When the count reaches TIMEOUT_CYCLES-1 with `ack` still 0: `sel_en`->0, `rsp_err`=01, `rsp_rdata`=0, go to RESP.
- RESP: `rsp_valid`=1 until `rsp_valid && rsp_ready`, then IDLE with `rsp_valid`->0 on the next edge. Fields are stable while `rsp_valid`=1.
- Stale ack guard: no new command is accepted while `ack`=1. The responder's ack trails `sel_en` deassert by one cycle, so a late or lingering ack can never complete the next access.
- Counter width is $clog2(TIMEOUT_CYCLES); it saturates and never wraps.
- Only one command is outstanding at a time; there is no pipelining.

## Timing
- Reset values (asynchronous, applied immediately):
  - `sel_en`, `wr_rd_s`, `rsp_valid` = 0.
  - `addr`, `wr_data`, `rsp_rdata` = 0; `rsp_err` = 00.
  - State IDLE, counter 0.
- Reset mid-access or mid-response: the command is dropped, no response is issued, and `sel_en` falls asynchronously.
- Legal access, responder acking one cycle after `sel_en`:
  - Accept in cycle 0.
  - `sel_en`=1 in cycles 1-2; `ack`=1 sampled at end of cycle 2.
  - `sel_en`=0 and `rsp_valid`=1 in cycle 3.
  - Command-to-response latency is 3 cycles.
- BAD_ADDR: `rsp_valid`=1 in cycle 1.
- TIMEOUT: `sel_en`=1 for exactly TIMEOUT_CYCLES cycles; `rsp_valid`=1 in the following cycle.
- `ack` rising in the same cycle the counter hits its limit: the ack wins and the response is OK.
- With `rsp_ready` held high, `rsp_valid` is one cycle wide. The next accept comes earliest in the cycle after that, and only once `ack`=0.

## Structure
- Shared package `reg_if_pkg`:
  - State enum (IDLE/ACCESS/RESP).
  - `rsp_err` codes: RSP_OK, RSP_TIMEOUT, RSP_BAD_ADDR.
  - Register-bus data and address width constants (8).
- One sub-module: `reg_timeout_cnt`, a saturating counter with clear and enable and an `expired` flag, parameterized by TIMEOUT_CYCLES.
- The FSM and datapath stay in the top level.

## Test plan
- Write addr 2, data 0xA5, responder acks next cycle: `sel_en` high in cycles 1-2 with `wr_rd_s`=1, `addr`=2, `wr_data`=0xA5. Responder `wr_en`=0x04. Cycle 3 gives `rsp_valid`=1, `rsp_err`=00, `rsp_rdata`=0.
- Read addr 1, responder register value 0x3C: `rsp_rdata`=0x3C, `rsp_err`=00, response in cycle 3.
- Read addr 5 with NUM_OF_REG=4: `sel_en` never rises; `rsp_valid` in cycle 1 with `rsp_err`=10 and `rsp_rdata`=0.
- `ack` tied 0, TIMEOUT_CYCLES=16: `sel_en` high exactly 16 cycles; then `rsp_err`=01 and `rsp_rdata`=0.
- Back-to-back commands with `rsp_ready` low for 3 cycles: the response is held stable, and `cmd_ready`=0 until the handshake completes and `ack`=0.
- `rst_n` pulsed low while `sel_en`=1: `sel_en` and `rsp_valid` drop immediately with no response. After release, `cmd_ready`=1 and a fresh read returns correct data.
